// File: rtl/full_adder_pkg.sv
// Shared constants and the reference sum for the registered ripple-carry full adder.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  // Reference (WIDTH_MAX+1)-bit true sum; callers zero-extend operands narrower than WIDTH_MAX.
  function automatic logic [WIDTH_MAX:0] ref_sum(
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b,
    input logic                 c
  );
    return {1'b0, a} + {1'b0, b} + {{WIDTH_MAX{1'b0}}, c};
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle of full_adder; the ovf wire exists only when FULL_ADDER_OVF_EN is defined.
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, c, input out_valid, s, co, ovf);
  modport slave  (input in_valid, a, b, c, output out_valid, s, co, ovf);
`else
  modport master (output in_valid, a, b, c, input out_valid, s, co);
  modport slave  (input in_valid, a, b, c, output out_valid, s, co);
`endif

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full-adder cell, the building block of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with valid tagging and one cycle of latency.
// Define FULL_ADDER_OVF_EN to register a two's-complement overflow flag next to the sum.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst,
  full_adder_if.slave bus
);

  logic [WIDTH:0]   k_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             out_valid_r;

  assign k_s[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (k_s[i]),
      .s  (sum_s[i]),
      .co (k_s[i+1])
    );
  end

  // Result registers load only on valid input, so idle (possibly unknown) operands never reach s/co.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      s_r         <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s_r  <= sum_s;
        co_r <= k_s[WIDTH];
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.co        = co_r;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_r;

  // Overflow is the carry into the sign bit disagreeing with the carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_r <= k_s[WIDTH] ^ k_s[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8 against a per-cycle arithmetic model.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   checking_on;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs, computed from plain integer arithmetic.
  logic       m1_v, m1_s, m1_co, m1_ovf;
  logic       m8_v, m8_co, m8_ovf;
  logic [7:0] m8_s;

  function automatic logic [1:0] res1(input logic a, input logic b, input logic c);
    logic [64:0] t;
    t = ref_sum({63'd0, a}, {63'd0, b}, c);
    return t[1:0];
  endfunction

  function automatic logic [8:0] res8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [64:0] t;
    t = ref_sum({56'd0, a}, {56'd0, b}, c);
    return t[8:0];
  endfunction

  function automatic logic sovf(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
    int sa, sb, sum, lim;
    lim = 1 << (w - 1);
    sa  = a[w-1] ? int'(a) - 2 * lim : int'(a);
    sb  = b[w-1] ? int'(b) - 2 * lim : int'(b);
    sum = sa + sb + int'(c);
    return (sum >= lim) || (sum < -lim);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m1_v <= 1'b0; m1_s <= 1'b0; m1_co <= 1'b0; m1_ovf <= 1'b0;
      m8_v <= 1'b0; m8_s <= 8'h00; m8_co <= 1'b0; m8_ovf <= 1'b0;
    end else begin
      m1_v <= bus1.in_valid;
      m8_v <= bus8.in_valid;
      if (bus1.in_valid) begin
        {m1_co, m1_s} <= res1(bus1.a, bus1.b, bus1.c);
        m1_ovf        <= sovf(1, {7'd0, bus1.a}, {7'd0, bus1.b}, bus1.c);
      end
      if (bus8.in_valid) begin
        {m8_co, m8_s} <= res8(bus8.a, bus8.b, bus8.c);
        m8_ovf        <= sovf(8, bus8.a, bus8.b, bus8.c);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    if (checking_on) begin
      chk("model1_valid", {63'd0, bus1.out_valid}, {63'd0, m1_v});
      chk("model1_s",     {63'd0, bus1.s},         {63'd0, m1_s});
      chk("model1_co",    {63'd0, bus1.co},        {63'd0, m1_co});
      chk("model8_valid", {63'd0, bus8.out_valid}, {63'd0, m8_v});
      chk("model8_s",     {56'd0, bus8.s},         {56'd0, m8_s});
      chk("model8_co",    {63'd0, bus8.co},        {63'd0, m8_co});
`ifdef FULL_ADDER_OVF_EN
      chk("model1_ovf",   {63'd0, bus1.ovf},       {63'd0, m1_ovf});
      chk("model8_ovf",   {63'd0, bus8.ovf},       {63'd0, m8_ovf});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic a, input logic b, input logic c);
    bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.c = c;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.c = c;
  endtask

  task automatic lit1(input string name, input logic v, input logic s, input logic co);
    chk({name, "_valid"}, {63'd0, bus1.out_valid}, {63'd0, v});
    chk({name, "_s"},     {63'd0, bus1.s},         {63'd0, s});
    chk({name, "_co"},    {63'd0, bus1.co},        {63'd0, co});
  endtask

  task automatic lit8(input string name, input logic [7:0] s, input logic co, input logic ovf);
    chk({name, "_valid"}, {63'd0, bus8.out_valid}, 64'd1);
    chk({name, "_s"},     {56'd0, bus8.s},         {56'd0, s});
    chk({name, "_co"},    {63'd0, bus8.co},        {63'd0, co});
`ifdef FULL_ADDER_OVF_EN
    chk({name, "_ovf"},   {63'd0, bus8.ovf},       {63'd0, ovf});
`else
    if (ovf !== 1'b0 && ovf !== 1'b1) $display("note: bad ovf literal in %s", name);
`endif
  endtask

  logic [7:0] tt_s  = 8'b1001_0110;
  logic [7:0] tt_co = 8'b1110_1000;

  initial begin
    logic [2:0] v;
    checks = 0;
    errors = 0;
    checking_on = 1'b0;
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);

    // Reset held two cycles while inputs are valid.
    tick();
    checking_on = 1'b1;
    lit1("reset_c1", 1'b0, 1'b0, 1'b0);
    chk("reset8_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("reset8_s", {56'd0, bus8.s}, 64'd0);
    tick();
    lit1("reset_c2", 1'b0, 1'b0, 1'b0);
`ifdef FULL_ADDER_OVF_EN
    chk("reset_ovf", {63'd0, bus1.ovf}, 64'd0);
`endif
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    lit1("first_after_reset", 1'b1, 1'b1, 1'b1);

    // Exhaustive 1-bit truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(1'b1, v[2], v[1], v[0]);
      tick();
      lit1($sformatf("truth_%0d", i), 1'b1, tt_s[i], tt_co[i]);
    end

    // Valid gap holds the last result with unknown operands.
    drive1(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    lit1("gap_load", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive1(1'b0, 1'bx, 1'bx, 1'bx);
      tick();
      lit1($sformatf("gap_hold_%0d", i), 1'b0, 1'b0, 1'b1);
    end

    // 8-bit carry ripple and signed-overflow corners.
    drive8(1'b1, 8'hFF, 8'h00, 1'b1); tick(); lit8("ripple_ff_00_1", 8'h00, 1'b1, 1'b0);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1); tick(); lit8("ripple_ff_ff_1", 8'hFF, 1'b1, 1'b0);
    drive8(1'b1, 8'h00, 8'h00, 1'b0); tick(); lit8("zero_00_00_0",   8'h00, 1'b0, 1'b0);
    drive8(1'b1, 8'h7F, 8'h01, 1'b0); tick(); lit8("ovf_7f_01_0",    8'h80, 1'b0, 1'b1);
    drive8(1'b1, 8'h80, 8'hFF, 1'b0); tick(); lit8("ovf_80_ff_0",    8'h7F, 1'b1, 1'b1);
    drive8(1'b1, 8'h5A, 8'h3C, 1'b1); tick(); lit8("mix_5a_3c_1",    8'h97, 1'b0, 1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset on the same edge as a valid input discards it.
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    lit1("midreset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    lit1("after_midreset", 1'b1, 1'b1, 1'b0);

    // Mixed traffic with random gaps, checked by the model only.
    for (int i = 0; i < 40; i++) begin
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    @(negedge clk);
    #1;
    checking_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
